// File: rtl/inst_sram_fetch_if.sv
// IF fetch bundle: PC-stage request/response plus the base SRAM read port.
// master = PC stage and SRAM side, slave = fetch unit.
interface inst_sram_fetch_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [31:0]           pc;
    logic                  ce;
    logic                  flush;
    logic [31:0]           inst;
    logic                  inst_valid;
    logic                  stall_req;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_data;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;

    modport master (
        output pc, ce, flush, sram_data,
        input  inst, inst_valid, stall_req, addr_err,
        input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  pc, ce, flush, sram_data,
        output inst, inst_valid, stall_req, addr_err,
        output sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/inst_sram_fetch.sv
// Instruction fetch from read-only base SRAM with fixed wait states.
// Optional misaligned-fetch trap: define IFETCH_ALIGN_CHECK_EN.
module inst_sram_fetch #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 20
) (
    input logic               clk,
    input logic               rst,
    inst_sram_fetch_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cen_q, cen_d;
    logic                  stall;
    logic                  misaligned;
    logic                  unused_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = |bus.pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign unused_pc = ^{bus.pc[31:ADDR_WIDTH+2], bus.pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            cen_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cen_q   <= cen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        cen_d   = cen_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = bus.ce & ~bus.flush;
                if (bus.ce && !bus.flush) begin
                    if (misaligned) begin
                        // trap without touching the SRAM: deliver a nop
                        state_d = DONE;
                        inst_d  = '0;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        addr_d  = bus.pc[ADDR_WIDTH+1:2];
                        cen_d   = 1'b0;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                    cen_d   = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    inst_d  = bus.sram_data;
                    valid_d = 1'b1;
                    cen_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // a flush in the delivery cycle must not let a stale word into IF/ID
    assign bus.inst_valid = valid_q & ~(bus.flush & (state_q == DONE));
    assign bus.inst       = inst_q;
    assign bus.addr_err   = err_q;
    assign bus.stall_req  = stall;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_ce_n  = cen_q;
    assign bus.sram_oe_n  = cen_q;
    assign bus.sram_we_n  = 1'b1;
endmodule

// File: tb/tb_inst_sram_fetch.sv
// Scoreboard bench for inst_sram_fetch: random fetches, flushes, resets,
// and a PC-stage model driving back-to-back requests.
module tb_inst_sram_fetch;
    localparam int W  = 2;
    localparam int AW = 20;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   low_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    inst_sram_fetch_if #(.ADDR_WIDTH(AW)) bus ();

    inst_sram_fetch #(
        .WAIT_CYCLES (W),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h2402_0001 ^ 32'h9E37_79B1;
    endfunction

    // SRAM: data is only good once ce_n/oe_n have been low for W cycles
    always @(posedge clk) begin
        if (bus.sram_ce_n) low_cnt <= 0;
        else               low_cnt <= low_cnt + 1;
    end

    assign bus.sram_data =
        (!bus.sram_ce_n && !bus.sram_oe_n && low_cnt >= W)
        ? mem_word(bus.sram_addr) : 32'h0BAD_0BAD;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard on every valid pulse
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (bus.inst_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got inst %h expected no pulse",
                         bus.inst);
            end else begin
                e = sb.pop_front();
                chk("inst", bus.inst, e.inst);
                chk("addr_err", 32'(bus.addr_err), 32'(e.err));
                if (e.cyc >= 0) chk("valid_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc >= 0 && cyc > sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: got none expected pulse at cycle %0d",
                     sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.ce    = 1'b0;
            bus.flush = 1'b0;
        end
    endtask

    // one isolated request; flush_at = cycle index after accept (0 = accept cycle)
    task automatic fetch(input logic [31:0] pc, input int flush_at);
        bit          mis;
        int          jdel;
        int          c0;
        exp_t        e;
        logic [AW-1:0] ea;
`ifdef IFETCH_ALIGN_CHECK_EN
        mis = (pc % 4) != 0;
`else
        mis = 1'b0;
`endif
        jdel = mis ? 1 : W + 2;
        ea   = AW'(pc >> 2);
        @(negedge clk);
        bus.pc    = pc;
        bus.ce    = 1'b1;
        bus.flush = (flush_at == 0);
        #1;
        chk("stall_accept", 32'(bus.stall_req), 32'(flush_at != 0));
        c0 = cyc + 1;
        if (flush_at > jdel) begin
            e.inst = mis ? 32'h0 : mem_word(ea);
            e.err  = mis;
            e.cyc  = c0 + jdel - 1;
            sb.push_back(e);
        end
        for (int j = 1; j <= jdel + 1; j++) begin
            @(negedge clk);
            bus.ce    = 1'b0;
            bus.flush = (j == flush_at);
            #1;
            if (!mis && flush_at != 0 && j <= W + 1 && j <= flush_at) begin
                chk("ce_n_access", 32'(bus.sram_ce_n), 32'd0);
                chk("oe_n_access", 32'(bus.sram_oe_n), 32'd0);
                chk("stall_access", 32'(bus.stall_req), 32'd1);
                chk("sram_addr", 32'(bus.sram_addr), 32'(ea));
            end
            if (mis && flush_at != 0 && j == 1) begin
                chk("ce_n_misaligned", 32'(bus.sram_ce_n), 32'd1);
                chk("stall_done", 32'(bus.stall_req), 32'd0);
            end
            if (j == jdel + 1 ||
                (!mis && flush_at != 0 && flush_at <= W + 1 && j == flush_at + 1)) begin
                chk("ce_n_idle", 32'(bus.sram_ce_n), 32'd1);
                chk("stall_idle", 32'(bus.stall_req), 32'd0);
            end
        end
    endtask

    // PC stage: holds ce high, advances pc whenever stall_req is low
    task automatic run_pc_stage(input logic [31:0] base, input int n);
        logic [31:0] cur;
        int          done;
        exp_t        e;
        cur  = base;
        done = 0;
        for (int k = 0; k < n; k++) begin
            e.inst = mem_word(AW'((base + 32'(4 * k)) >> 2));
            e.err  = 1'b0;
            e.cyc  = -1;
            sb.push_back(e);
        end
        for (int k = 0; k < n * (W + 6) + 10 && done < n; k++) begin
            @(negedge clk);
            bus.pc    = cur;
            bus.ce    = 1'b1;
            bus.flush = 1'b0;
            #1;
            if (!bus.stall_req) begin
                done++;
                cur = cur + 32'd4;
            end
        end
        checks++;
        if (done != n) begin
            errors++;
            $display("FAIL pc_stage_timeout: got %0d words expected %0d", done, n);
        end
        idle(W + 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          fa;
        rst       = 1'b1;
        bus.pc    = '0;
        bus.ce    = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_err", 32'(bus.addr_err), 32'd0);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        fetch(32'h8000_0004, 99);
        idle(1);
        run_pc_stage(32'h8000_0000, 3);

        fetch(32'h8000_0020, 2);
        fetch(32'h8000_0100, 99);
        fetch(32'h8000_0200, W + 2);
        idle(2);

        @(negedge clk);
        bus.pc = 32'h8000_0040;
        bus.ce = 1'b1;
        @(negedge clk);
        bus.ce = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rst_mid_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("rst_mid_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_mid_stall", 32'(bus.stall_req), 32'd0);
        fetch(32'h8000_0044, 99);

        fetch(32'h8000_0002, 99);
        fetch(32'h8000_0003, 1);
        idle(1);

        for (int i = 0; i < 40; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc = pc & 32'hFFFF_FFFC;
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W + 2)) : 99;
            fetch(pc, fa);
            idle(int'($urandom_range(0, 2)));
        end
        run_pc_stage(32'h0012_3450, 5);

        idle(10);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
